lca_add_arbiter: RTL

Round-robin arbiter and sequencer that shares one 64-bit lookahead-carry adder between NREQ requesters, for example the ALU add/sub path, branch target AGU, load/store AGU and multiplier accumulate. Each request carries two 64-bit operands and an add/sub select. The block registers the winning operands into a single issue stage, drives the shared adder, and returns the result through a one-entry output buffer with a valid/ready handshake. Requesters are identified by an ID, so no requester sees another's result.

---
 rtl/lca_add_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lca_add_arbiter.sv
// Round-robin arbiter sharing one 64-bit lookahead-carry adder among NREQ requesters.
// Two registered stages (issue, result buffer) with a valid/ready result handshake.
module lca_add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*64-1:0] req_a,
    input  logic [NREQ*64-1:0] req_b,
    input  logic [NREQ-1:0]    req_sub,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [63:0]        rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_ovf,
    output logic               busy
);
    localparam int unsigned DW = 64;

    // Encoding is {iss_valid, rsp_valid}.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        DONE   = 2'b01,
        ISSUED = 2'b10,
        FULL   = 2'b11
    } state_t;

    function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Three-level lookahead: 4-bit blocks, 16-bit super-blocks, 64-bit top g/p.
    function automatic logic [DW:0] cla64(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic cin);
        logic [DW-1:0] g, p, c;
        logic [15:0]   bg, bp, bc;
        logic [3:0]    sg, sp, sc;
        logic          gt, pt;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 16; k++) begin
            bg[k] = grp_g(g[4*k +: 4], p[4*k +: 4]);
            bp[k] = &p[4*k +: 4];
        end
        for (int j = 0; j < 4; j++) begin
            sg[j] = grp_g(bg[4*j +: 4], bp[4*j +: 4]);
            sp[j] = &bp[4*j +: 4];
        end
        gt = grp_g(sg, sp);
        pt = &sp;
        sc[0] = cin;
        for (int j = 1; j < 4; j++) begin
            sc[j] = sg[j-1] | (sp[j-1] & sc[j-1]);
        end
        for (int j = 0; j < 4; j++) begin
            bc[4*j] = sc[j];
            for (int i = 1; i < 4; i++) begin
                bc[4*j+i] = bg[4*j+i-1] | (bp[4*j+i-1] & bc[4*j+i-1]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            c[4*k] = bc[k];
            for (int i = 1; i < 4; i++) begin
                c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
            end
        end
        return {gt | (pt & cin), p ^ c};
    endfunction

    // First valid requester scanning upward from ptr, wrapping modulo NREQ.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
        logic           found;
        logic [IDW-1:0] pick;
        logic [31:0]    idx;
        found = 1'b0;
        pick  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = (32'(ptr) + off) % NREQ;
            if (!found && v[IDW'(idx)]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
        return {found, pick};
    endfunction

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr, win;
    logic           found, grant, s1_free, s2_free;
    logic           iss_valid, iss_cin;
    logic [IDW-1:0] iss_id;
    logic [DW-1:0]  iss_a, iss_bx, sel_a, sel_b;
    logic           sel_sub;
    logic [DW:0]    add_res;
    logic           add_ovf;

    assign iss_valid = state_q[1];
    assign rsp_valid = state_q[0];

    // Grant and occupancy next-state.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        s2_free   = !rsp_valid || rsp_ready;
        s1_free   = !iss_valid || s2_free;
        {found, win} = rr_pick(req_valid, rr_ptr);
        grant     = s1_free && found && !rst;
        if (grant) req_ready[win] = 1'b1;
        case (state_q)
            EMPTY:   if (grant) state_d = ISSUED;
            ISSUED:  state_d = grant ? FULL : DONE;
            DONE:    if (rsp_ready) state_d = grant ? ISSUED : EMPTY;
                     else           state_d = grant ? FULL : DONE;
            FULL:    if (rsp_ready) state_d = grant ? FULL : DONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_a   = req_a[64*i +: 64];
                sel_b   = req_b[64*i +: 64];
                sel_sub = req_sub[i];
            end
        end
    end

    always_comb begin
        add_res = cla64(iss_a, iss_bx, iss_cin);
        add_ovf = (iss_a[DW-1] == iss_bx[DW-1]) && (add_res[DW-1] != iss_a[DW-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rr_ptr   <= '0;
            busy     <= 1'b0;
            iss_id   <= '0;
            iss_a    <= '0;
            iss_bx   <= '0;
            iss_cin  <= 1'b0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != EMPTY);
            if (grant) begin
                rr_ptr  <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
                iss_id  <= win;
                iss_a   <= sel_a;
                iss_bx  <= sel_sub ? ~sel_b : sel_b;
                iss_cin <= sel_sub;
            end
            if (iss_valid && s2_free) begin
                rsp_id   <= iss_id;
                rsp_sum  <= add_res[DW-1:0];
                rsp_cout <= add_res[DW];
                rsp_ovf  <= add_ovf;
            end
        end
    end
endmodule
